simplex_tx_init_ctrl: RTL and testbench

//  Sequences a simplex Aurora TX lane through reset, lane alignment, channel bonding and verification.

---
 rtl/simplex_pkg.sv | 43 ++++
 rtl/simplex_tx_timer.sv | 36 +++
 rtl/simplex_tx_init_ctrl.sv | 137 +++++++++++++
 tb/tb_simplex_tx_init_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/simplex_pkg.sv
// Shared types for the simplex Aurora TX init controller: ordered-set selects,
// init FSM state encoding and small elaboration-time helpers.
package simplex_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_ALIGN  = 3'd1,
        SEQ_BOND   = 3'd2,
        SEQ_VERIFY = 3'd3,
        SEQ_DATA   = 3'd4
    } tx_seq_e;

    typedef enum logic [2:0] {
        RST    = 3'd0,
        ALIGN  = 3'd1,
        BOND   = 3'd2,
        VERIFY = 3'd3,
        READY  = 3'd4
    } init_state_e;

    function automatic tx_seq_e seq_for_state(input init_state_e s);
        tx_seq_e seq;
        case (s)
            ALIGN:   seq = SEQ_ALIGN;
            BOND:    seq = SEQ_BOND;
            VERIFY:  seq = SEQ_VERIFY;
            READY:   seq = SEQ_DATA;
            default: seq = SEQ_IDLE;
        endcase
        return seq;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/simplex_tx_timer.sv
// Loadable down-counter that parks at zero; expired is high while it reads zero.
// Load has priority over counting, so a state entry always restarts the window.
module simplex_tx_timer #(
    parameter int unsigned     W       = 4,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/simplex_tx_init_ctrl.sv
// Simplex TX lane init sequencer: RST -> ALIGN -> BOND -> VERIFY -> READY driven by far-RX status.
// Outputs are registered from the next state, so they change on the same edge as the state.
module simplex_tx_init_ctrl
    import simplex_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned ALIGN_TIMEOUT  = 4096,
    parameter int unsigned BOND_TIMEOUT   = 4096,
    parameter int unsigned VERIFY_TIMEOUT = 4096,
    parameter int unsigned VERIFY_HOLD    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       aligned,
    input  logic       bonded,
    input  logic       verified,
    input  logic       rx_reset,
    output logic [2:0] tx_seq_sel,
    output logic       tx_lane_rst,
    output logic       channel_up,
    output logic [7:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int unsigned TMR_W  = $clog2(max4(RST_CYCLES, ALIGN_TIMEOUT,
                                                 BOND_TIMEOUT, VERIFY_TIMEOUT)) + 1;
    localparam int unsigned HOLD_W = $clog2(VERIFY_HOLD + 1);

    localparam logic [TMR_W-1:0]  RST_LD    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]  ALIGN_LD  = TMR_W'(ALIGN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  BOND_LD   = TMR_W'(BOND_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  VERIFY_LD = TMR_W'(VERIFY_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(VERIFY_HOLD - 1);

    init_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        retry_q, retry_d;
    tx_seq_e           seq_q;
    logic              lane_rst_q;
    logic              ch_up_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_expired;
    logic              restart;

    simplex_tx_timer #(
        .W       (TMR_W),
        .RST_VAL (RST_LD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    // Status losses fall back to the deepest step still valid; timeout only when nothing else applies.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            RST: begin
                if (tmr_expired) state_d = ALIGN;
            end
            ALIGN, BOND, VERIFY, READY: begin
                if (rx_reset) begin
                    state_d = RST;
                end else if (!aligned && state_q != ALIGN) begin
                    state_d = ALIGN;
                end else if (!bonded && (state_q == VERIFY || state_q == READY)) begin
                    state_d = BOND;
                end else if (!verified && state_q == READY) begin
                    state_d = VERIFY;
                end else if (tmr_expired && state_q != READY) begin
                    state_d = RST;
                    restart = 1'b1;
                end else begin
                    case (state_q)
                        ALIGN:   if (aligned) state_d = BOND;
                        BOND:    if (bonded) state_d = VERIFY;
                        VERIFY:  if (verified && hold_q == HOLD_LAST) state_d = READY;
                        default: state_d = state_q;
                    endcase
                end
            end
            default: state_d = RST;
        endcase
    end

    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = RST_LD;
        case (state_d)
            ALIGN:   tmr_load_val = ALIGN_LD;
            BOND:    tmr_load_val = BOND_LD;
            VERIFY:  tmr_load_val = VERIFY_LD;
            default: tmr_load_val = RST_LD;
        endcase
    end

    always_comb begin
        hold_d = '0;
        if (state_q == VERIFY && state_d == VERIFY && verified) begin
            hold_d = hold_q + 1'b1;
        end
        retry_d = retry_q;
        if (restart && retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RST;
            hold_q     <= '0;
            retry_q    <= 8'd0;
            seq_q      <= SEQ_IDLE;
            lane_rst_q <= 1'b1;
            ch_up_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            retry_q    <= retry_d;
            seq_q      <= seq_for_state(state_d);
            lane_rst_q <= (state_d == RST);
            ch_up_q    <= (state_d == READY);
        end
    end

    assign tx_seq_sel  = seq_q;
    assign tx_lane_rst = lane_rst_q;
    assign channel_up  = ch_up_q;
    assign retry_cnt   = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_simplex_tx_init_ctrl.sv
// Directed bench for the simplex TX init sequencer with short timers.
module tb_simplex_tx_init_ctrl;

    localparam logic [2:0] S_RST = 3'd0, S_ALIGN = 3'd1, S_BOND = 3'd2,
                           S_VERIFY = 3'd3, S_READY = 3'd4;
    localparam logic [2:0] Q_IDLE = 3'd0, Q_ALIGN = 3'd1, Q_BOND = 3'd2,
                           Q_DATA = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       aligned = 1'b0, bonded = 1'b0, verified = 1'b0, rx_reset = 1'b0;
    logic [2:0] tx_seq_sel;
    logic       tx_lane_rst;
    logic       channel_up;
    logic [7:0] retry_cnt;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    simplex_tx_init_ctrl #(
        .RST_CYCLES     (4),
        .ALIGN_TIMEOUT  (32),
        .BOND_TIMEOUT   (32),
        .VERIFY_TIMEOUT (32),
        .VERIFY_HOLD    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aligned     (aligned),
        .bonded      (bonded),
        .verified    (verified),
        .rx_reset    (rx_reset),
        .tx_seq_sel  (tx_seq_sel),
        .tx_lane_rst (tx_lane_rst),
        .channel_up  (channel_up),
        .retry_cnt   (retry_cnt),
        .state_dbg   (state_dbg)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (state_dbg !== S_RST || tx_seq_sel !== Q_IDLE || tx_lane_rst !== 1'b1 ||
            channel_up !== 1'b0 || retry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset: state=%0d seq=%0d lrst=%b up=%b retry=%0d required 0 0 1 0 0",
                     state_dbg, tx_seq_sel, tx_lane_rst, channel_up, retry_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bringup();
        logic [2:0] exp;
        for (int k = 1; k <= 26; k++) begin
            if (k == 11) aligned = 1'b1;
            if (k == 16) bonded = 1'b1;
            if (k == 21) verified = 1'b1;
            tick();
            exp = (k < 4) ? S_RST : (k < 11) ? S_ALIGN : (k < 16) ? S_BOND :
                  (k < 24) ? S_VERIFY : S_READY;
            checks++;
            if (state_dbg !== exp) begin
                errors++;
                $display("FAIL bringup_state k=%0d: got %0d required %0d", k, state_dbg, exp);
            end
        end
        checks++;
        if (channel_up !== 1'b1 || tx_seq_sel !== Q_DATA || tx_lane_rst !== 1'b0) begin
            errors++;
            $display("FAIL ready_outputs: up=%b seq=%0d lrst=%b required 1 4 0",
                     channel_up, tx_seq_sel, tx_lane_rst);
        end
    endtask

    task automatic test_timeout();
        aligned = 1'b0;
        tick();
        checks++;
        if (state_dbg !== S_ALIGN || channel_up !== 1'b0 || tx_seq_sel !== Q_ALIGN) begin
            errors++;
            $display("FAIL ready_lose_align: state=%0d up=%b seq=%0d required 1 0 1",
                     state_dbg, channel_up, tx_seq_sel);
        end
        for (int i = 0; i < 31; i++) tick();
        checks++;
        if (state_dbg !== S_ALIGN) begin
            errors++;
            $display("FAIL align_before_timeout: got %0d required %0d", state_dbg, S_ALIGN);
        end
        tick();
        checks++;
        if (state_dbg !== S_RST || retry_cnt !== 8'd1 || tx_lane_rst !== 1'b1) begin
            errors++;
            $display("FAIL align_timeout: state=%0d retry=%0d lrst=%b required 0 1 1",
                     state_dbg, retry_cnt, tx_lane_rst);
        end
        for (int i = 0; i < 36; i++) tick();
        checks++;
        if (state_dbg !== S_RST || retry_cnt !== 8'd2) begin
            errors++;
            $display("FAIL second_restart: state=%0d retry=%0d required 0 2", state_dbg, retry_cnt);
        end
        for (int i = 0; i < 298 * 36; i++) tick();
        checks++;
        if (state_dbg !== S_RST || retry_cnt !== 8'd255) begin
            errors++;
            $display("FAIL retry_saturate: state=%0d retry=%0d required 0 255", state_dbg, retry_cnt);
        end
    endtask

    task automatic wait_state(input logic [2:0] want, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (state_dbg === want) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: state=%0d required %0d within 20 cycles", name, state_dbg, want);
        end
    endtask

    task automatic test_verify_hold();
        logic [7:0] pat;
        logic [2:0] exp;
        pat = 8'b1111_0111;
        aligned  = 1'b1;
        bonded   = 1'b1;
        verified = 1'b0;
        wait_state(S_VERIFY, "reach_verify");
        for (int i = 0; i < 8; i++) begin
            verified = pat[i];
            tick();
            exp = (i == 7) ? S_READY : S_VERIFY;
            checks++;
            if (state_dbg !== exp) begin
                errors++;
                $display("FAIL verify_hold i=%0d: got %0d required %0d", i, state_dbg, exp);
            end
        end
    endtask

    task automatic test_double_drop();
        bonded   = 1'b0;
        verified = 1'b0;
        tick();
        checks++;
        if (state_dbg !== S_BOND || channel_up !== 1'b0 || tx_seq_sel !== Q_BOND) begin
            errors++;
            $display("FAIL double_drop: state=%0d up=%b seq=%0d required 2 0 2",
                     state_dbg, channel_up, tx_seq_sel);
        end
    endtask

    task automatic test_rx_reset();
        bonded   = 1'b1;
        verified = 1'b1;
        wait_state(S_READY, "reach_ready");
        rx_reset = 1'b1;
        aligned  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (state_dbg !== S_RST || tx_lane_rst !== 1'b1 || tx_seq_sel !== Q_IDLE) begin
                errors++;
                $display("FAIL rx_reset_rst cycle=%0d: state=%0d lrst=%b seq=%0d required 0 1 0",
                         i, state_dbg, tx_lane_rst, tx_seq_sel);
            end
        end
        tick();
        checks++;
        if (state_dbg !== S_ALIGN || tx_lane_rst !== 1'b0 || retry_cnt !== 8'd255) begin
            errors++;
            $display("FAIL rx_reset_exit: state=%0d lrst=%b retry=%0d required 1 0 255",
                     state_dbg, tx_lane_rst, retry_cnt);
        end
        rx_reset = 1'b0;
    endtask

    task automatic test_midseq_reset();
        aligned  = 1'b1;
        bonded   = 1'b1;
        verified = 1'b0;
        wait_state(S_VERIFY, "reach_verify2");
        rst_n = 1'b0;
        tick();
        checks++;
        if (state_dbg !== S_RST || tx_seq_sel !== Q_IDLE || tx_lane_rst !== 1'b1 ||
            channel_up !== 1'b0 || retry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midseq_reset: state=%0d seq=%0d lrst=%b up=%b retry=%0d required 0 0 1 0 0",
                     state_dbg, tx_seq_sel, tx_lane_rst, channel_up, retry_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (state_dbg !== S_RST) begin
            errors++;
            $display("FAIL midseq_rst_hold: got %0d required %0d", state_dbg, S_RST);
        end
        tick();
        checks++;
        if (state_dbg !== S_ALIGN) begin
            errors++;
            $display("FAIL midseq_to_align: got %0d required %0d", state_dbg, S_ALIGN);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_verify_hold();
        test_double_drop();
        test_rx_reset();
        test_midseq_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
